instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Generates the sequential fetch PC and issues in-order word reads to instruction memory.
- Buffers returned instructions with their PCs in a FIFO, and presents them to the decoder through a valid/ready handshake.
- On a redirect from the back end (branch/jump resolution), flushes the FIFO and discards stale in-flight responses.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered imem requests; 1..DEPTH.
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response valid. In order, never back-pressured, latency ≥1 cycle.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  back-end redirect.
- redirect_pc  in  32  new fetch PC; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decoder consumes the head.
- out_instr  out  32  head instruction; feeds the decoder's instr input.
- out_pc  out  32  head PC.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC; FIFO empty; outstanding=0; drop=0; state=RUN.
  - imem_req_valid=0 and out_valid=0 while rst_n=0.
- State:
  - pc: fetch PC.
  - FIFO: entries of {pc, instr}.
  - outstanding: count of accepted, unanswered requests.
  - drop: count of stale responses still to discard.
  - FSM state: RUN or FLUSH.
- Issue rule (combinational): imem_req_valid = (state==RUN) && !redirect_valid && outstanding<MAX_OUTSTANDING && (occupancy+outstanding)<DEPTH. This reservation guarantees every response has a free slot.
- imem_req_addr=pc. On handshake: pc<=pc+4 (wraps mod 2^32), outstanding++. Each request's pc is pushed into an in-order pending-PC queue of MAX_OUTSTANDING entries.
- Response in RUN: pop the pending PC and write {pc, data} into the FIFO; outstanding--.
- Response in FLUSH: discard it; drop--, outstanding--.
  - FLUSH→RUN when drop reaches 0, including the cycle that decrements it to 0.
  - If a redirect arrives while outstanding==0, go straight to RUN.
- A request and a response in the same cycle: outstanding is unchanged.
- Output:
  - out_valid = occupancy≠0; out_instr/out_pc come from the head entry.
  - Pop on out_valid&&out_ready.
  - A simultaneous push and pop is legal when full (after the pop) or empty (no bypass).
  - Minimum latency: request accepted at cycle N, response at N+1, out_valid at N+2.
- Redirect (highest priority, any state):
  - pc<=redirect_pc&~3; FIFO cleared; pending queue cleared.
  - drop<=outstanding after accounting for any response arriving in the same cycle; that response is itself discarded.
  - state<=FLUSH if the resulting drop>0, else RUN.
  - No request is issued in the redirect cycle. A pop in the redirect cycle is ignored; out_valid=0 the next cycle.
- Back-to-back redirects: the later one wins and drop is recomputed each time.
- No branch delay slots in this core: instructions after a redirect are never delivered.

Optional Feature:
- Macro: IFQ_JUMP_PREDECODE_EN.
- Defined:
  - When a RUN response with opcode 6'h02 (j) or 6'h03 (jal) is written, it still enters the FIFO.
  - The same cycle performs an internal redirect to {entry_pc[31:28]+... no: {(entry_pc+4)[31:28], data[25:0], 2'b00}, without clearing the FIFO. Younger outstanding requests become drop; state is FLUSH if drop>0.
  - An external redirect in the same cycle overrides it.
- Undefined: no predecode; jumps are handled only via redirect_valid.

Decomposition:
- Shared package/structs.svh:
  - ifq_entry_t {pc, instr}.
  - ifq_state_t {IFQ_RUN, IFQ_FLUSH}.
  - Opcode constants OPC_J_RAW=6'h02 and OPC_JAL_RAW=6'h03, reused by the decoder's opcode mapping.
- One sub-module: sync_fifo (parameterised width/depth, clear input, count output). It is used for the instruction FIFO and for the pending-PC queue.

Test Plan:
- Reset, imem fixed latency 1, out_ready=1 → requests at 0x3000, 0x3004…; out_pc sequence 0x3000, 0x3004…; first out_valid two cycles after the first handshake.
- out_ready=0 for 20 cycles → occupancy+outstanding never exceeds 8; imem_req_valid drops; no response lost; FIFO holds PCs 0x3000–0x301C in order.
- 3 requests outstanding, redirect_pc=0x3403 → next request addr 0x3400 only after 3 responses are discarded; the first out_pc after the redirect is 0x3400.
- Redirect in the same cycle as a response and a pop with outstanding=2 → that response is discarded, drop=1, out_valid=0 next cycle.
- Redirects on two consecutive cycles (0x4000, then 0x5000) → fetch resumes at 0x5000; no 0x4000 entry is ever output.
- IFQ_JUMP_PREDECODE_EN, word at 0x3008=0x08000d00 (j) → j is delivered at 0x3008; next out_pc=0x00003400; 0x300C is never output.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue and the decoder.
// Raw opcode constants are reused by the decoder's opcode mapping.
package instr_fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    typedef enum logic {
        IFQ_RUN,
        IFQ_FLUSH
    } ifq_state_t;

    localparam logic [5:0] OPC_J_RAW   = 6'h02;
    localparam logic [5:0] OPC_JAL_RAW = 6'h03;

    function automatic logic is_jump(input logic [31:0] instr);
        return (instr[31:26] == OPC_J_RAW) || (instr[31:26] == OPC_JAL_RAW);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Synchronous FIFO with clear and occupancy count.
// Depth need not be a power of two; clear wins over push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is only legal when the head leaves this cycle
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC generation, imem request issue and instruction buffering.
// Optional jump predecode is enabled by defining IFQ_JUMP_PREDECODE_EN.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH           = 8,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    ifq_state_t    state;
    ifq_state_t    state_nxt;
    logic [31:0]   pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] outstanding_nxt;
    logic [OW-1:0] drop;
    logic [OW-1:0] drop_nxt;
    logic [CW-1:0] occupancy;
    logic [OW-1:0] pend_count;
    logic [31:0]   pend_pc;
    ifq_entry_t    head;
    ifq_entry_t    wr_entry;
    logic          req_fire;
    logic          resp_run;
    logic          pop_fire;
    logic          jump_hit;
    logic [31:0]   jump_target;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign resp_run = imem_resp_valid && (state == IFQ_RUN)
                      && !redirect_valid && (pend_count != '0);
    assign pop_fire = out_valid && out_ready;
    assign wr_entry = '{pc: pend_pc, instr: imem_resp_data};

    assign outstanding_nxt = outstanding + OW'(req_fire)
                             - OW'(imem_resp_valid);

`ifdef IFQ_JUMP_PREDECODE_EN
    logic [31:0] entry_pc_next;
    assign entry_pc_next = pend_pc + 32'd4;
    assign jump_hit      = resp_run && is_jump(imem_resp_data);
    assign jump_target   = {entry_pc_next[31:28], imem_resp_data[25:0], 2'b00};
`else
    assign jump_hit    = 1'b0;
    assign jump_target = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IFQ_RUN;
        else        state <= state_nxt;
    end

    // Stale responses still in flight decide whether we sit in FLUSH
    always_comb begin
        drop_nxt = drop;
        if (redirect_valid)
            drop_nxt = outstanding - OW'(imem_resp_valid);
        else if (jump_hit)
            drop_nxt = outstanding_nxt;
        else if (state == IFQ_FLUSH && imem_resp_valid && drop != '0)
            drop_nxt = drop - 1'b1;
        state_nxt = (drop_nxt != '0) ? IFQ_FLUSH : IFQ_RUN;
    end

    // Occupancy plus outstanding reserves a slot for every response
    always_comb begin
        imem_req_valid = 1'b0;
        if (rst_n && state == IFQ_RUN && !redirect_valid
            && outstanding < OW'(MAX_OUTSTANDING)
            && ({1'b0, occupancy} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH))
            imem_req_valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop        <= drop_nxt;
            if (redirect_valid)
                pc <= redirect_pc & ~32'd3;
            else if (jump_hit)
                pc <= jump_target;
            else if (req_fire)
                pc <= pc + 32'd4;
        end
    end

    assign imem_req_addr = pc;
    assign out_valid     = rst_n && (occupancy != '0);
    assign out_pc        = head.pc;
    assign out_instr     = head.instr;

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_ifq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (resp_run),
        .push_data (wr_entry),
        .pop       (pop_fire),
        .head      (head),
        .count     (occupancy)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid || jump_hit),
        .push      (req_fire),
        .push_data (pc),
        .pop       (resp_run),
        .head      (pend_pc),
        .count     (pend_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int DEPTH = 8;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    instr_fetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (32'h0000_3000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       mq[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] delivered[$];
    int          m_out, m_drop;
    bit          m_flush;
    logic [31:0] m_pc;
    bit          exp_req;

    int          nvec, nfail, cyc;
    int          lat = 1;
    bit          dec_ready = 1'b1, mem_ready = 1'b1, rv = 1'b0;
    logic [31:0] rp = '0;
    bit          hs;
    logic [31:0] hs_addr, first_addr;
    int          hs_cnt, resp_cnt, first_hs, first_ov;
    bit          arm, fired;
    logic [31:0] arm_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef IFQ_JUMP_PREDECODE_EN
        if (a == 32'h3008) return 32'h0800_0d00;
`endif
        return {6'h23, a[27:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check();
        exp_req = rst_n && !m_flush && !redirect_valid && (m_out < MAXO)
                  && ((m_fifo.size() + m_out) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(rst_n && m_fifo.size() > 0));
        if (rst_n && m_fifo.size() > 0) begin
            chk("out_pc", out_pc, m_fifo[0].pc);
            chk("out_instr", out_instr, m_fifo[0].instr);
        end
    endtask

    task automatic model_step();
        bit          resp;
        bit          fire;
        bit          jump;
        logic [31:0] p, w, p4, tgt;
        resp = imem_resp_valid;
        jump = 1'b0;
        tgt  = '0;
        if (!rst_n) begin
            m_fifo.delete();
            m_pend.delete();
            m_out   = 0;
            m_drop  = 0;
            m_flush = 1'b0;
            m_pc    = 32'h3000;
            return;
        end
        fire = exp_req && imem_req_ready;
        if (redirect_valid) begin
            m_fifo.delete();
            m_pend.delete();
            if (resp) m_out--;
            m_drop  = m_out;
            m_flush = (m_drop > 0);
            m_pc    = redirect_pc & ~32'h3;
            return;
        end
        if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
        if (resp) begin
            m_out--;
            if (m_flush) begin
                m_drop--;
                if (m_drop == 0) m_flush = 1'b0;
            end else begin
                p = m_pend.pop_front();
                w = mem_word(p);
                m_fifo.push_back('{pc: p, instr: w});
`ifdef IFQ_JUMP_PREDECODE_EN
                if (w[31:26] == 6'h02 || w[31:26] == 6'h03) begin
                    jump = 1'b1;
                    p4   = p + 32'd4;
                    tgt  = {p4[31:28], w[25:0], 2'b00};
                end
`endif
            end
        end
        if (fire) begin
            m_pend.push_back(m_pc);
            m_pc += 32'd4;
            m_out++;
        end
        if (jump) begin
            m_pend.delete();
            m_pc    = tgt;
            m_drop  = m_out;
            m_flush = (m_drop > 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!rst_n) mq.delete();
        else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq[0].data;
            void'(mq.pop_front());
            resp_cnt++;
        end
        out_ready      = dec_ready;
        imem_req_ready = mem_ready;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (arm && imem_resp_valid && m_out == 2 && m_fifo.size() > 0
            && dec_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm   = 1'b0;
            fired = 1'b1;
        end
        #1;
        check();
        hs = rst_n && imem_req_valid && imem_req_ready;
        if (hs) begin
            hs_addr = imem_req_addr;
            hs_cnt++;
            mq.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
            if (first_hs < 0) begin
                first_hs   = cyc;
                first_addr = imem_req_addr;
            end
        end
        if (rst_n && out_valid && first_ov < 0) first_ov = cyc;
        if (rst_n && out_valid && out_ready && !redirect_valid)
            delivered.push_back(out_pc);
        model_step();
        cyc++;
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rv    = 1'b0;
        arm   = 1'b0;
        repeat (2) tick();
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        delivered.delete();
        hs_cnt   = 0;
        resp_cnt = 0;
        first_hs = -1;
        first_ov = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int idx;

        // Straight-line fetch, latency 1, decoder always ready
        lat = 1; dec_ready = 1'b1; mem_ready = 1'b1;
        do_reset();
        repeat (12) tick();
        chk("t1_first_addr", first_addr, 32'h3000);
        chk("t1_latency", 32'(first_ov - first_hs), 32'd2);
        for (int i = 0; i < 4; i++)
            chk("t1_seq", delivered[i], 32'h3000 + 32'(4 * i));

        // Decoder stalled: reservation caps in-flight plus buffered at DEPTH
        dec_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        chk("t2_hs_count", 32'(hs_cnt), 32'd8);
        #1;
        chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        dec_ready = 1'b1;
        delivered.delete();
        repeat (12) tick();
        for (int i = 0; i < 8; i++)
            chk("t2_order", delivered[i], 32'h3000 + 32'(4 * i));

        // Redirect with three requests in flight
        lat = 8;
        do_reset();
        repeat (3) tick();
        chk("t3_hs_count", 32'(hs_cnt), 32'd3);
        mem_ready = 1'b0;
        rv = 1'b1; rp = 32'h3403;
        tick();
        rv = 1'b0;
        mem_ready = 1'b1;
        resp_cnt = 0;
        hs_cnt = 0;
        delivered.delete();
        for (int i = 0; i < 30 && hs_cnt == 0; i++) tick();
        chk("t3_resume", 32'(hs_cnt), 32'd1);
        chk("t3_addr", hs_addr, 32'h3400);
        chk("t3_dropped", 32'(resp_cnt), 32'd3);
        repeat (12) tick();
        chk("t3_first_out", delivered[0], 32'h3400);

        // Redirect coinciding with a response and a pop, two in flight
        lat = 2;
        do_reset();
        arm = 1'b1; arm_pc = 32'h3800; fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) tick();
        chk("t4_fired", 32'(fired), 32'd1);
        #1;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        hs_cnt = 0;
        resp_cnt = 0;
        delivered.delete();
        for (int i = 0; i < 20 && hs_cnt == 0; i++) tick();
        chk("t4_dropped", 32'(resp_cnt), 32'd1);
        chk("t4_addr", hs_addr, 32'h3800);

        // Back-to-back redirects: the later target wins
        rv = 1'b1; rp = 32'h4000;
        tick();
        rp = 32'h5000;
        tick();
        rv = 1'b0;
        delivered.delete();
        repeat (15) tick();
        chk("t5_first_out", delivered[0], 32'h5000);
        bad = 0;
        foreach (delivered[i]) if (delivered[i][31:12] == 20'h4) bad++;
        chk("t5_no_4000", 32'(bad), 32'd0);

`ifdef IFQ_JUMP_PREDECODE_EN
        // Predecoded j at 0x3008 steers fetch to 0x3400
        lat = 1;
        do_reset();
        repeat (20) tick();
        idx = -1;
        bad = 0;
        foreach (delivered[i]) begin
            if (delivered[i] == 32'h3008 && idx < 0) idx = i;
            if (delivered[i] == 32'h300C) bad++;
        end
        chk("t6_j_seen", 32'(idx >= 0), 32'd1);
        if (idx >= 0) chk("t6_target", delivered[idx + 1], 32'h3400);
        chk("t6_no_300c", 32'(bad), 32'd0);
`else
        idx = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
